// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the fetch program-counter generator.
// Holds the FSM state encoding, the sequential PC step and the default vectors.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } pc_state_e;

  localparam int          PC_INC           = 4;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

endpackage

// File: rtl/pc_gen_ras_stack.sv
// Circular return-address stack: saturating count, overwrite-oldest on overflow.
// Simultaneous push+pop on a non-empty stack replaces the top in place.
module ras_stack #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic            i_clear,
  input  logic [XLEN-1:0] i_data,
  output logic [XLEN-1:0] o_top,
  output logic            o_empty,
  output logic            o_full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0] r_mem [RAS_DEPTH];
  logic [PW-1:0]   r_ptr;
  logic [CW-1:0]   r_cnt;
  logic            w_empty;
  logic            w_replace;
  logic [PW-1:0]   w_ptr_inc;

  assign w_empty   = (r_cnt == '0);
  assign w_replace = i_push && i_pop && !w_empty;
  assign w_ptr_inc = r_ptr + 1'b1;
  assign o_top     = r_mem[r_ptr];
  assign o_empty   = w_empty;
  assign o_full    = (r_cnt == CW'(RAS_DEPTH));

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (w_replace) begin
      r_ptr <= r_ptr;
    end else if (i_push) begin
      r_ptr <= w_ptr_inc;
      if (!o_full) r_cnt <= r_cnt + 1'b1;
    end else if (i_pop && !w_empty) begin
      r_ptr <= r_ptr - 1'b1;
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Storage is not reset; only pointer and count define validity.
  always_ff @(posedge clk) begin
    if (!rst && !i_clear) begin
      if (w_replace)   r_mem[r_ptr]     <= i_data;
      else if (i_push) r_mem[w_ptr_inc] <= i_data;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: BOOT/RUN/FAULT control, trap/redirect priority,
// sequential advance and return-address prediction through ras_stack.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEF_TRAP_VECTOR),
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic            ras_push,
  input  logic            ras_pop,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            misalign_fault,
  output logic            ras_empty
);

  pc_state_e       r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt, w_pc_inc, w_ras_top;
  logic            r_pc_valid, r_fault;
  logic            w_push, w_pop, w_clear, w_ras_empty;

  assign w_pc_inc = r_pc + XLEN'(PC_INC);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_clear     = 1'b0;
    if (trap_valid) begin
      w_state_nxt = ST_RUN;
      w_pc_nxt    = TRAP_VECTOR;
      w_clear     = 1'b1;
    end else begin
      case (r_state)
        ST_BOOT: begin
          w_state_nxt = ST_RUN;
          w_pc_nxt    = RESET_VECTOR;
        end
        ST_RUN: begin
          if (redirect_valid) begin
            // Misaligned target parks the PC and stops issuing until a trap.
            if (redirect_target[1:0] == 2'b00) w_pc_nxt = redirect_target;
            else                               w_state_nxt = ST_FAULT;
          end else if (fetch_ready) begin
            w_push   = ras_push;
            w_pop    = ras_pop;
            w_pc_nxt = (ras_pop && !w_ras_empty) ? w_ras_top : w_pc_inc;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_BOOT;
      r_pc       <= RESET_VECTOR;
      r_pc_valid <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_pc_valid <= (w_state_nxt == ST_RUN);
      r_fault    <= (w_state_nxt == ST_FAULT);
    end
  end

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (w_clear),
    .i_data  (w_pc_inc),
    .o_top   (w_ras_top),
    .o_empty (w_ras_empty),
    .o_full  ()
  );

  assign pc             = r_pc;
  assign pc_valid       = r_pc_valid;
  assign misalign_fault = r_fault;
  assign ras_empty      = w_ras_empty;

endmodule

// File: tb/tb_pc_gen.sv
// Directed vector table for pc_gen plus hand sequences for FAULT hold and trap-from-BOOT.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        trap_valid = 1'b0;
  logic        ras_push = 1'b0;
  logic        ras_pop = 1'b0;
  logic [31:0] pc;
  logic        pc_valid, misalign_fault, ras_empty;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_ready     (fetch_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap_valid      (trap_valid),
    .ras_push        (ras_push),
    .ras_pop         (ras_pop),
    .pc              (pc),
    .pc_valid        (pc_valid),
    .misalign_fault  (misalign_fault),
    .ras_empty       (ras_empty)
  );

  typedef struct {
    logic        rst, fr, rv;
    logic [31:0] tgt;
    logic        trap, push, pop;
    logic [31:0] epc;
    logic        ev, ef, ee;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic fr, input logic rv, input logic [31:0] tgt,
                     input logic trap, input logic push, input logic pop,
                     input logic [31:0] epc, input logic ev, input logic ef, input logic ee);
    vec_t v;
    v.rst = r; v.fr = fr; v.rv = rv; v.tgt = tgt; v.trap = trap; v.push = push; v.pop = pop;
    v.epc = epc; v.ev = ev; v.ef = ef; v.ee = ee;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic fr, input logic rv, input logic [31:0] tgt,
                       input logic trap, input logic push, input logic pop);
    rst = r; fetch_ready = fr; redirect_valid = rv; redirect_target = tgt;
    trap_valid = trap; ras_push = push; ras_pop = pop;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] epc, input logic ev,
                         input logic ef, input logic ee);
    chk({tag, ".pc"}, pc, epc);
    chk({tag, ".pc_valid"}, {31'b0, pc_valid}, {31'b0, ev});
    chk({tag, ".misalign_fault"}, {31'b0, misalign_fault}, {31'b0, ef});
    chk({tag, ".ras_empty"}, {31'b0, ras_empty}, {31'b0, ee});
  endtask

  initial begin
    //  rst fr rv tgt           trap push pop  epc           v  f  e
    add(1, 0, 0, 32'h0,         0, 0, 0,   32'h0000_0000, 0, 0, 1); // reset -> BOOT
    add(0, 1, 0, 32'h0,         0, 0, 0,   32'h0000_0000, 1, 0, 1); // BOOT -> RUN
    add(0, 1, 0, 32'h0,         0, 0, 0,   32'h0000_0004, 1, 0, 1);
    add(0, 1, 0, 32'h0,         0, 0, 0,   32'h0000_0008, 1, 0, 1);
    add(0, 1, 0, 32'h0,         0, 0, 0,   32'h0000_000C, 1, 0, 1);
    add(0, 1, 0, 32'h0,         0, 0, 0,   32'h0000_0010, 1, 0, 1);
    add(0, 1, 1, 32'h200,       0, 0, 0,   32'h0000_0200, 1, 0, 1); // redirect beats advance
    add(0, 0, 0, 32'h0,         0, 0, 0,   32'h0000_0200, 1, 0, 1); // stall holds
    add(0, 1, 1, 32'h202,       0, 0, 0,   32'h0000_0200, 0, 1, 1); // misaligned -> FAULT
    add(0, 1, 1, 32'h300,       0, 0, 0,   32'h0000_0200, 0, 1, 1); // redirect ignored
    add(0, 1, 0, 32'h0,         0, 1, 0,   32'h0000_0200, 0, 1, 1); // push ignored in FAULT
    add(0, 0, 0, 32'h0,         1, 0, 0,   32'h0000_0100, 1, 0, 1); // trap recovers
    add(0, 1, 0, 32'h0,         0, 0, 0,   32'h0000_0104, 1, 0, 1);
    add(0, 0, 1, 32'h40,        0, 0, 0,   32'h0000_0040, 1, 0, 1);
    add(0, 1, 0, 32'h0,         0, 1, 0,   32'h0000_0044, 1, 0, 0); // push 0x44
    add(0, 0, 1, 32'h80,        0, 0, 0,   32'h0000_0080, 1, 0, 0);
    add(0, 1, 0, 32'h0,         0, 1, 0,   32'h0000_0084, 1, 0, 0); // push 0x84
    add(0, 0, 1, 32'hC0,        0, 0, 0,   32'h0000_00C0, 1, 0, 0);
    add(0, 1, 0, 32'h0,         0, 1, 0,   32'h0000_00C4, 1, 0, 0); // push 0xC4
    add(0, 0, 1, 32'h100,       0, 0, 0,   32'h0000_0100, 1, 0, 0);
    add(0, 1, 0, 32'h0,         0, 1, 0,   32'h0000_0104, 1, 0, 0); // push 0x104 (full)
    add(0, 0, 1, 32'h140,       0, 0, 0,   32'h0000_0140, 1, 0, 0);
    add(0, 1, 0, 32'h0,         0, 1, 0,   32'h0000_0144, 1, 0, 0); // push 0x144 evicts 0x44
    add(0, 1, 0, 32'h0,         0, 0, 1,   32'h0000_0144, 1, 0, 0);
    add(0, 1, 0, 32'h0,         0, 0, 1,   32'h0000_0104, 1, 0, 0);
    add(0, 1, 0, 32'h0,         0, 0, 1,   32'h0000_00C4, 1, 0, 0);
    add(0, 1, 0, 32'h0,         0, 0, 1,   32'h0000_0084, 1, 0, 1);
    add(0, 1, 0, 32'h0,         0, 0, 1,   32'h0000_0088, 1, 0, 1); // pop empty -> pc+4
    add(0, 1, 0, 32'h0,         0, 1, 0,   32'h0000_008C, 1, 0, 0); // push 0x8C
    add(0, 1, 0, 32'h0,         0, 1, 1,   32'h0000_008C, 1, 0, 0); // push+pop: top -> 0x90
    add(0, 1, 0, 32'h0,         0, 0, 1,   32'h0000_0090, 1, 0, 1);
    add(0, 1, 0, 32'h0,         0, 1, 1,   32'h0000_0094, 1, 0, 0); // push+pop empty = push
    add(0, 1, 0, 32'h0,         1, 0, 0,   32'h0000_0100, 1, 0, 1); // trap clears RAS
    add(0, 1, 0, 32'h0,         0, 0, 1,   32'h0000_0104, 1, 0, 1);
    add(0, 1, 0, 32'h0,         1, 1, 0,   32'h0000_0100, 1, 0, 1); // push ignored on trap
    add(0, 0, 0, 32'h0,         0, 0, 1,   32'h0000_0100, 1, 0, 1); // pop ignored on stall
    add(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0,   32'hFFFF_FFFC, 1, 0, 1);
    add(0, 1, 0, 32'h0,         0, 1, 0,   32'h0000_0000, 1, 0, 0); // wrap, pushed 0x0
    add(0, 1, 0, 32'h0,         0, 0, 1,   32'h0000_0000, 1, 0, 1); // pop wrapped addr
    add(0, 1, 1, 32'h400,       1, 0, 0,   32'h0000_0100, 1, 0, 1); // trap beats redirect
    add(0, 1, 1, 32'h203,       0, 0, 0,   32'h0000_0100, 0, 1, 1); // FAULT again
    add(1, 1, 1, 32'h400,       1, 1, 0,   32'h0000_0000, 0, 0, 1); // rst beats trap
    add(0, 1, 0, 32'h0,         0, 0, 0,   32'h0000_0000, 1, 0, 1);

    @(negedge clk);
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].fr, tbl[i].rv, tbl[i].tgt, tbl[i].trap, tbl[i].push, tbl[i].pop);
      chk_all($sformatf("vec%0d", i), tbl[i].epc, tbl[i].ev, tbl[i].ef, tbl[i].ee);
    end

    // FAULT must hold across arbitrary redirect/fetch/RAS activity until a trap.
    drive(1, 0, 0, 32'h0, 0, 0, 0);
    drive(0, 1, 0, 32'h0, 0, 0, 0);
    drive(0, 1, 0, 32'h0, 0, 0, 0);
    drive(0, 1, 1, 32'h6, 0, 0, 0);
    chk_all("seq_fault_entry", 32'h4, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      drive(0, 1'($urandom), 1'($urandom), {$urandom} & 32'hFFFF_FFFC, 0,
            1'($urandom), 1'($urandom));
      chk_all($sformatf("seq_fault_hold%0d", k), 32'h4, 1'b0, 1'b1, 1'b1);
    end
    drive(1, 0, 0, 32'h0, 1, 0, 0);
    chk_all("seq_fault_rst", 32'h0, 1'b0, 1'b0, 1'b1);

    // Trap taken directly from BOOT, then pc unchanged before the next edge.
    drive(0, 1, 0, 32'h0, 1, 0, 0);
    chk_all("seq_boot_trap", 32'h100, 1'b1, 1'b0, 1'b1);
    rst = 0; fetch_ready = 1; trap_valid = 0; redirect_valid = 1; redirect_target = 32'h80;
    #3;
    chk("seq_redirect_latency_pre", pc, 32'h100);
    @(posedge clk);
    #1;
    chk("seq_redirect_latency_post", pc, 32'h80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
